// File: rtl/bus2_arbiter.sv
// Round-robin arbiter for the RISC SPM Bus_2: one-hot grant and 3:1 mux select, bounded hold per holder.
// One-cycle req->gnt latency, all outputs from registers; requesters hold req until served, hold-limit expiry preempts.
module bus2_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       bus_busy,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LIM = MAX_HOLD[3:0];

  state_t     state, state_nxt;
  logic [1:0] holder, holder_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       pre_q, pre_nxt;

  logic [2:0] others;
  logic [2:0] pick_all;
  logic [2:0] pick_oth;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Returns {found, index}: first set bit of r searching ptr+1, ptr+2, ptr+3 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] c;
    logic [2:0] res;
    res = 3'b000;
    c   = p;
    for (int i = 0; i < 3; i++) begin
      c = inc3(c);
      if (!res[2] && r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign others   = req & ~onehot(holder);
  assign pick_all = rr_pick(req, ptr);
  assign pick_oth = rr_pick(others, ptr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      holder <= 2'd0;
      ptr    <= 2'd2;
      cnt    <= 4'd0;
      pre_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      holder <= holder_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      pre_q  <= pre_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    holder_nxt = holder;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    pre_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_all[2]) begin
          state_nxt  = GRANT;
          holder_nxt = pick_all[1:0];
          ptr_nxt    = pick_all[1:0];
          cnt_nxt    = 4'd1;
        end
      end
      GRANT: begin
        if (!req[holder]) begin
          if (pick_oth[2]) begin
            holder_nxt = pick_oth[1:0];
            ptr_nxt    = pick_oth[1:0];
            cnt_nxt    = 4'd1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end else if (cnt < HOLD_LIM) begin
          cnt_nxt = cnt + 4'd1;
        end else if (pick_oth[2]) begin
          // ptr equals the holder here, so the search over others never returns it
          holder_nxt = pick_oth[1:0];
          ptr_nxt    = pick_oth[1:0];
          cnt_nxt    = 4'd1;
          pre_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt      = 3'b000;
    sel      = 2'b11;
    bus_busy = 1'b0;
    preempt  = pre_q;
    if (state == GRANT) begin
      gnt      = onehot(holder);
      sel      = holder;
      bus_busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_bus2_arbiter.sv
// Directed bench for bus2_arbiter: MAX_HOLD=4 instance for the main scenarios, MAX_HOLD=1 instance for rotation.
module tb_bus2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, req1;
  logic [2:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       bus_busy, bus_busy1, preempt, preempt1;

  int checks = 0;
  int errors = 0;

  // {gnt, sel, bus_busy, preempt}
  localparam logic [6:0] O_IDLE = 7'b000_11_0_0;
  localparam logic [6:0] O_G0   = 7'b001_00_1_0;
  localparam logic [6:0] O_G1   = 7'b010_01_1_0;
  localparam logic [6:0] O_G2   = 7'b100_10_1_0;
  localparam logic [6:0] O_P0   = 7'b001_00_1_1;
  localparam logic [6:0] O_P1   = 7'b010_01_1_1;
  localparam logic [6:0] O_P2   = 7'b100_10_1_1;

  bus2_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .sel(sel), .bus_busy(bus_busy), .preempt(preempt)
  );

  bus2_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .gnt(gnt1), .sel(sel1), .bus_busy(bus_busy1), .preempt(preempt1)
  );

  always #5 clk = ~clk;

  wire [6:0] obs  = {gnt, sel, bus_busy, preempt};
  wire [6:0] obs1 = {gnt1, sel1, bus_busy1, preempt1};

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got gnt/sel/busy/pre=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    req  = 3'b000;
    req1 = 3'b000;
    tick();
    chk("reset_c1", obs, O_IDLE);
    tick();
    chk("reset_c2", obs, O_IDLE);

    // single request
    rst = 1'b1;
    req = 3'b010;
    tick();
    chk("single_gnt", obs, O_G1);
    req = 3'b000;
    tick();
    chk("single_rel", obs, O_IDLE);

    // simultaneous requests from reset, each drops after one granted cycle
    do_reset();
    req = 3'b111;
    tick();
    chk("simul_g0", obs, O_G0);
    req = 3'b110;
    tick();
    chk("simul_g1", obs, O_G1);
    req = 3'b100;
    tick();
    chk("simul_g2", obs, O_G2);
    req = 3'b000;
    tick();
    chk("simul_idle", obs, O_IDLE);

    // hold-limit preemption with MAX_HOLD=4
    do_reset();
    req = 3'b001;
    tick();
    chk("hold_c1", obs, O_G0);
    tick();
    chk("hold_c2", obs, O_G0);
    req = 3'b101;
    tick();
    chk("hold_c3", obs, O_G0);
    tick();
    chk("hold_c4", obs, O_G0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        if (p % 2 == 0) chk($sformatf("alt_p%0d_k%0d", p, k), obs, (k == 0) ? O_P2 : O_G2);
        else            chk($sformatf("alt_p%0d_k%0d", p, k), obs, (k == 0) ? O_P0 : O_G0);
      end
    end
    req = 3'b000;
    tick();
    chk("hold_idle", obs, O_IDLE);

    // saturation without contention, then late competitor
    req = 3'b100;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("sat_c%0d", i), obs, O_G2);
    end
    req = 3'b110;
    tick();
    chk("sat_preempt", obs, O_P1);
    tick();
    chk("sat_after", obs, O_G1);
    req = 3'b000;
    tick();
    chk("sat_idle", obs, O_IDLE);

    // reset while holder 1 is at cnt=3
    req = 3'b010;
    tick();
    tick();
    tick();
    chk("mid_cnt3", obs, O_G1);
    req = 3'b011;
    rst = 1'b0;
    tick();
    chk("mid_reset", obs, O_IDLE);
    rst = 1'b1;
    tick();
    chk("mid_regrant", obs, O_G0);
    req = 3'b000;
    tick();
    chk("mid_idle", obs, O_IDLE);

    // MAX_HOLD=1 rotation
    do_reset();
    req1 = 3'b111;
    tick();
    chk("mh1_g0", obs1, O_G0);
    tick();
    chk("mh1_g1", obs1, O_P1);
    tick();
    chk("mh1_g2", obs1, O_P2);
    tick();
    chk("mh1_g0b", obs1, O_P0);
    tick();
    chk("mh1_g1b", obs1, O_P1);
    chk("mh1_other_idle", obs, O_IDLE);
    req1 = 3'b000;
    tick();
    chk("mh1_idle", obs1, O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
